// File: rtl/mips_pkg.sv
// Shared types and defaults for the MIPS instruction-fetch front end.
package mips_pkg;

   localparam int unsigned          DEFAULT_XLEN     = 32;
   localparam logic [31:0]          DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [31:0]          PC_STEP          = 32'd4;

   // One queued instruction together with the address it was fetched from.
   typedef struct packed {
      logic [DEFAULT_XLEN-1:0] pc;
      logic [DEFAULT_XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries; flush wins over push and pop.
// When empty, head keeps presenting the last entry that was at the head.
module fetch_fifo
   import mips_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  fetch_entry_t           din,
   output fetch_entry_t           head,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   fetch_entry_t  mem_q [DEPTH];
   fetch_entry_t  mem_d [DEPTH];
   fetch_entry_t  hold_q, hold_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          not_empty, do_push, do_pop;

   // Next-state for storage, pointers, occupancy and the held head value.
   always_comb begin
      not_empty = (count_q != '0);
      do_pop    = pop && !flush && not_empty;
      do_push   = push && !flush && ((count_q != FULL_CNT) || do_pop);
      mem_d     = mem_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = din;
      end
      hold_d = not_empty ? mem_q[rd_ptr_q] : hold_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         wr_ptr_d = wr_ptr_q + PW'(do_push);
         rd_ptr_d = rd_ptr_q + PW'(do_pop);
         count_d  = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '{default: '0};
         hold_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         hold_q   <= hold_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head  = not_empty ? mem_q[rd_ptr_q] : hold_q;
   assign count = count_q;

endmodule

// File: rtl/mips_fetch_unit.sv
// Decoupled instruction prefetcher: credit-limited requests, in-order
// responses into an instruction queue, redirect with stale-response drop.
module mips_fetch_unit
   import mips_pkg::*;
#(
   parameter int unsigned     XLEN     = DEFAULT_XLEN,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic            CLK,
   input  logic            Reset,
   output logic            ReqValid,
   input  logic            ReqReady,
   output logic [XLEN-1:0] ReqAddr,
   input  logic            RespValid,
   input  logic [XLEN-1:0] RespData,
   input  logic            RedirectValid,
   input  logic [XLEN-1:0] RedirectPC,
   input  logic            StallD,
   output logic            InstrValidD,
   output logic [XLEN-1:0] InstrD,
   output logic [XLEN-1:0] PCD,
   output logic [XLEN-1:0] PCPlus4D,
   output logic [XLEN-1:0] FetchPC
);

   localparam int unsigned   CW      = $clog2(DEPTH) + 1;
   localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);
   localparam logic [XLEN-1:0] STEP  = XLEN'(PC_STEP);

   logic [XLEN-1:0] req_pc_q, req_pc_d;
   logic [XLEN-1:0] resp_pc_q, resp_pc_d;
   logic [CW-1:0]   outstanding_q, outstanding_d;
   logic [CW-1:0]   drop_q, drop_d;
   logic [CW-1:0]   count;
   logic [CW:0]     inflight;
   logic            req_fire, resp_ok, resp_keep, pop;
   fetch_entry_t    push_entry, head;

   // Credit check from registered occupancy, handshake and queue control.
   always_comb begin
      inflight    = {1'b0, count} + {1'b0, outstanding_q};
      ReqValid    = Reset && !RedirectValid && (inflight < DEPTH_W);
      req_fire    = ReqValid && ReqReady;
      resp_ok     = RespValid && (outstanding_q != '0);
      resp_keep   = resp_ok && !RedirectValid && (drop_q == '0);
      InstrValidD = (count != '0);
      pop         = InstrValidD && !StallD && !RedirectValid;
      push_entry  = '{pc: resp_pc_q, instr: RespData};
   end

   // PC, outstanding and drop bookkeeping; a redirect re-arms drop with every
   // response still in flight after this cycle's one.
   always_comb begin
      req_pc_d      = req_pc_q;
      resp_pc_d     = resp_pc_q;
      drop_d        = drop_q;
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(resp_ok);
      if (RedirectValid) begin
         req_pc_d  = RedirectPC;
         resp_pc_d = RedirectPC;
         drop_d    = outstanding_q - CW'(resp_ok);
      end else begin
         if (req_fire) begin
            req_pc_d = req_pc_q + STEP;
         end
         if (resp_ok) begin
            if (drop_q != '0) begin
               drop_d = drop_q - CW'(1);
            end else begin
               resp_pc_d = resp_pc_q + STEP;
            end
         end
      end
   end

   // Fetch state registers with asynchronous active-low reset.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         req_pc_q      <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         drop_q        <= '0;
      end else begin
         req_pc_q      <= req_pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (CLK),
      .rst_n (Reset),
      .push  (resp_keep),
      .pop   (pop),
      .flush (RedirectValid),
      .din   (push_entry),
      .head  (head),
      .count (count)
   );

   assign InstrD   = head.instr;
   assign PCD      = head.pc;
   assign PCPlus4D = head.pc + STEP;
   assign ReqAddr  = req_pc_q;
   assign FetchPC  = req_pc_q;

endmodule
